// File: rtl/dfn_misr_bank.sv
// WIDTH-bit register bank with clock enable, capture, scan shift and MISR
// compression; a shift counter pulses done when a full scan load completes.
module dfn_misr_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] POLY      = 8'hB8,
  parameter int               SHIFT_LEN = WIDTH
) (
  input  logic             cp,
  input  logic             rn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] z,
  output logic             so,
  output logic             done
);

  localparam int CW = (SHIFT_LEN < 2) ? 1 : $clog2(SHIFT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFT_LEN - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_CAPT  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_MISR  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_z;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_z_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_fb;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);
  assign w_fb   = ^(r_z & POLY);

  // en=0 freezes z and the count; done only ever lasts the cycle after the
  // completing shift, so it defaults low on every edge.
  always_comb begin
    w_z_nxt    = r_z;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (en) begin
      w_cnt_nxt = '0;
      case (w_mode)
        MODE_HOLD: w_z_nxt = r_z;
        MODE_CAPT: w_z_nxt = d;
        MODE_SHIFT: begin
          w_z_nxt = {r_z[WIDTH-2:0], si};
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        MODE_MISR: w_z_nxt = {r_z[WIDTH-2:0], w_fb} ^ d;
        default:   w_z_nxt = r_z;
      endcase
    end
  end

  always_ff @(posedge cp) begin
    if (!rn) begin
      r_z    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_z    <= w_z_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign z    = r_z;
  assign so   = r_z[WIDTH-1];
  assign done = r_done;

endmodule

// File: tb/tb_dfn_misr_bank.sv
// Directed bench for dfn_misr_bank at WIDTH=4, POLY=4'b1001, SHIFT_LEN=4.
module tb_dfn_misr_bank;

  localparam int W = 4;

  logic         cp;
  logic         rn;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         si;
  logic [W-1:0] z;
  logic         so;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  dfn_misr_bank #(
    .WIDTH    (W),
    .POLY     (4'b1001),
    .SHIFT_LEN(4)
  ) u_dut (
    .cp  (cp),
    .rn  (rn),
    .en  (en),
    .mode(mode),
    .d   (d),
    .si  (si),
    .z   (z),
    .so  (so),
    .done(done)
  );

  // clock / reset
  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one active edge, then settle before sampling
  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic drive(input logic rn_v, input logic en_v, input logic [1:0] mode_v,
                       input logic [W-1:0] d_v, input logic si_v);
    rn = rn_v; en = en_v; mode = mode_v; d = d_v; si = si_v;
  endtask

  task automatic shift(input logic si_v);
    drive(1'b1, 1'b1, 2'b10, 4'h0, si_v);
    step();
  endtask

  task automatic load_zero();
    drive(1'b1, 1'b1, 2'b01, 4'h0, 1'b0);
    step();
  endtask

  initial begin
    logic [3:0] si_pat;
    drive(1'b1, 1'b1, 2'b01, 4'hF, 1'b0);
    @(negedge cp);

    // reset overrides capture
    rn = 1'b0;
    step();
    check("rst_z", z, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_so", so, 1'b0);
    rn = 1'b1;
    step();
    check("post_rst_capture", z, 4'hF);

    // capture with enable gating
    drive(1'b1, 1'b0, 2'b01, 4'hA, 1'b0);
    step();
    step();
    check("en0_hold", z, 4'hF);
    en = 1'b1;
    step();
    check("capture_z", z, 4'hA);
    check("capture_so", so, 1'b1);

    // hold mode
    drive(1'b1, 1'b1, 2'b00, 4'h5, 1'b1);
    step();
    check("hold_z", z, 4'hA);

    // scan load 1,0,1,1
    load_zero();
    si_pat = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      shift(si_pat[i]);
      if (i != 0) check("load_done_early", done, 1'b0);
    end
    check("load_z", z, 4'b1011);
    check("load_done", done, 1'b1);
    check("load_so", so, 1'b1);
    shift(1'b0);
    check("fifth_shift_z", z, 4'b0110);
    check("fifth_shift_done", done, 1'b0);

    // interrupted by mode 00: count restarts
    load_zero();
    shift(1'b1);
    shift(1'b1);
    drive(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
    step();
    check("intr_hold_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      shift(1'b0);
      check("intr_done_early", done, 1'b0);
    end
    shift(1'b1);
    check("intr_done", done, 1'b1);
    check("intr_z", z, 4'b0001);

    // en=0 mid-sequence keeps the count
    load_zero();
    shift(1'b1);
    shift(1'b0);
    drive(1'b1, 1'b0, 2'b10, 4'h0, 1'b1);
    step();
    step();
    check("en0_shift_z", z, 4'b0010);
    check("en0_shift_done", done, 1'b0);
    shift(1'b1);
    check("en0_resume_early", done, 1'b0);
    shift(1'b1);
    check("en0_resume_done", done, 1'b1);
    check("en0_resume_z", z, 4'b1011);
    // done must drop when the following edge is disabled
    drive(1'b1, 1'b0, 2'b10, 4'h0, 1'b0);
    step();
    check("en0_kills_done", done, 1'b0);
    check("en0_kills_done_z", z, 4'b1011);

    // MISR sequence via expected queue
    drive(1'b1, 1'b1, 2'b01, 4'b0001, 1'b0);
    step();
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1110);
    drive(1'b1, 1'b1, 2'b11, 4'h0, 1'b0);
    while (exp_q.size() > 0) begin
      step();
      check("misr_z", z, exp_q.pop_front());
      check("misr_done", done, 1'b0);
    end
    d = 4'b0101;
    step();
    check("misr_d_z", z, 4'b1000);

    // reset priority mid-shift
    load_zero();
    shift(1'b1);
    shift(1'b1);
    shift(1'b1);
    drive(1'b0, 1'b1, 2'b10, 4'h0, 1'b1);
    step();
    check("rst_mid_z", z, 4'h0);
    check("rst_mid_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      shift(1'b1);
      check("rst_mid_early", done, 1'b0);
    end
    shift(1'b0);
    check("rst_mid_done4", done, 1'b1);
    check("rst_mid_z4", z, 4'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
